// File: rtl/frame_buffer.sv
// Single-clock W*H pixel framebuffer: registered read/write, whole-frame fill engine, XOR-masked storage.
// Define FB_BOUNDS_CHECK_EN to reject out-of-range read/write with an err pulse.
module frame_buffer #(
  parameter int W = 200,
  parameter int H = 150,
  parameter int DW = 12,
  parameter int XW = 8,
  parameter int YW = 8,
  parameter logic [DW-1:0] INIT_COLOR = 12'hFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          read,
  input  logic          write,
  input  logic          fill,
  input  logic [XW-1:0] X,
  input  logic [YW-1:0] Y,
  input  logic [DW-1:0] DATIN,
  output logic [DW-1:0] DATOUT,
  output logic          rValid,
  output logic          wAck,
  output logic          busy,
  output logic          fillDone,
  output logic          err,
  output logic [DW-1:0] wDbg
);

  localparam int AW = $clog2(W * H);
  localparam logic [AW-1:0] LAST_ADDR = AW'(W * H - 1);

  typedef enum logic [0:0] {IDLE, FILL} state_t;

  state_t          state;
  logic [AW-1:0]   fill_addr;
  logic [DW-1:0]   fill_color;
  logic [AW-1:0]   pix_addr;
  logic            in_range;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_din;

  logic [DW-1:0] mem [W*H];

  // Widen both operands before the multiply so Y*W never truncates at XW/YW.
  assign pix_addr = AW'(Y) * AW'(W) + AW'(X);

`ifdef FB_BOUNDS_CHECK_EN
  assign in_range = (32'(X) < 32'(W)) && (32'(Y) < 32'(H));
`else
  assign in_range = 1'b1;
`endif

  // Single shared write port: the fill engine owns it while in FILL.
  assign mem_we   = !rst && ((state == FILL) ||
                             ((state == IDLE) && !fill && !read && write && in_range));
  assign mem_addr = (state == FILL) ? fill_addr : pix_addr;
  assign mem_din  = ((state == FILL) ? fill_color : DATIN) ^ INIT_COLOR;

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_addr] <= mem_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fill_addr  <= '0;
      fill_color <= '0;
      DATOUT     <= INIT_COLOR;
      rValid     <= 1'b0;
      wAck       <= 1'b0;
      busy       <= 1'b0;
      fillDone   <= 1'b0;
      wDbg       <= '0;
    end else begin
      rValid   <= 1'b0;
      wAck     <= 1'b0;
      fillDone <= 1'b0;
      case (state)
        IDLE: begin
          if (fill) begin
            fill_color <= DATIN;
            fill_addr  <= '0;
            busy       <= 1'b1;
            state      <= FILL;
          end else if (read) begin
            if (in_range) begin
              DATOUT <= mem[pix_addr] ^ INIT_COLOR;
              rValid <= 1'b1;
            end
          end else if (write) begin
            if (in_range) begin
              wDbg <= DATIN;
              wAck <= 1'b1;
            end
          end
        end
        FILL: begin
          if (fill_addr == LAST_ADDR) begin
            busy     <= 1'b0;
            fillDone <= 1'b1;
            wDbg     <= fill_color;
            state    <= IDLE;
          end else begin
            fill_addr <= fill_addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FB_BOUNDS_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else
      err <= (state == IDLE) && !fill && (read || write) && !in_range;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_buffer.sv
// Scoreboard bench for frame_buffer: read expectations are queued at request time and popped on rValid.
module tb_frame_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic        fill = 1'b0;
  logic [7:0]  X = '0;
  logic [7:0]  Y = '0;
  logic [11:0] DATIN = '0;
  logic [11:0] DATOUT;
  logic        rValid, wAck, busy, fillDone, err;
  logic [11:0] wDbg;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q [$];

  frame_buffer dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .fill(fill),
    .X(X), .Y(Y), .DATIN(DATIN), .DATOUT(DATOUT), .rValid(rValid),
    .wAck(wAck), .busy(busy), .fillDone(fillDone), .err(err), .wDbg(wDbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; drains the scoreboard on rValid.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rValid) begin
      if (exp_q.size() == 0) check("rvalid_spurious", rValid, 1'b0);
      else check("rdata", DATOUT, exp_q.pop_front());
    end
  endtask

  task automatic do_read(input int x, input int y, input logic [11:0] exp);
    X = 8'(x); Y = 8'(y); read = 1'b1;
    exp_q.push_back(exp);
    tick();
    read = 1'b0;
    check("read_served", exp_q.size(), 0);
    $display("read  (%0d,%0d) -> %03h", x, y, DATOUT);
  endtask

  task automatic do_write(input int x, input int y, input logic [11:0] d);
    X = 8'(x); Y = 8'(y); DATIN = d; write = 1'b1;
    tick();
    write = 1'b0;
    check("wack", wAck, 1'b1);
    check("wdbg", wDbg, d);
    $display("write (%0d,%0d) <- %03h", x, y, d);
  endtask

  initial begin
    int cnt;
    logic [11:0] d;
    int x, y;

    // Reset with requests pending: nothing may respond.
    read = 1'b1; write = 1'b1;
    repeat (3) tick();
    check("rst_rvalid", rValid, 1'b0);
    check("rst_wack", wAck, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_filldone", fillDone, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_wdbg", wDbg, 12'h000);
    check("rst_datout", DATOUT, 12'hFFF);
    read = 1'b0; write = 1'b0;
    rst = 1'b0;
    tick();
    $display("reset released");

    do_read(0, 0, 12'hFFF);
    tick();
    check("rvalid_single", rValid, 1'b0);

    do_write(5, 3, 12'h0A5);
    do_read(5, 3, 12'h0A5);
    check("wdbg_hold", wDbg, 12'h0A5);

    // read + write together: read wins, write dropped.
    X = 8'd7; Y = 8'd7; DATIN = 12'h111; read = 1'b1; write = 1'b1;
    exp_q.push_back(12'hFFF);
    tick();
    read = 1'b0; write = 1'b0;
    check("rw_no_wack", wAck, 1'b0);
    check("rw_read_served", exp_q.size(), 0);
    $display("read+write (7,7) -> %03h", DATOUT);
    do_read(7, 7, 12'hFFF);

    // Back-to-back reads.
    X = 8'd5; Y = 8'd3; read = 1'b1; exp_q.push_back(12'h0A5);
    tick();
    X = 8'd0; Y = 8'd0; exp_q.push_back(12'hFFF);
    tick();
    read = 1'b0;
    check("b2b_served", exp_q.size(), 0);
    $display("back-to-back reads done");

    // Fill 123 with an ignored write and read mid-fill.
    DATIN = 12'h123; fill = 1'b1;
    tick();
    fill = 1'b0;
    check("fill_busy", busy, 1'b1);
    cnt = 1;
    while (cnt < 40000) begin
      if (cnt == 10) begin
        X = 8'd10; Y = 8'd10; DATIN = 12'h777; write = 1'b1;
      end else if (cnt == 11) begin
        write = 1'b0; read = 1'b1;
      end else begin
        write = 1'b0; read = 1'b0;
      end
      tick();
      if (wAck) check("fill_wack", wAck, 1'b0);
      if (!busy) break;
      cnt++;
    end
    read = 1'b0; write = 1'b0;
    check("fill_cycles", cnt, 30000);
    check("fill_done", fillDone, 1'b1);
    check("fill_wdbg", wDbg, 12'h123);
    $display("fill 123 busy cycles=%0d", cnt);
    do_read(0, 0, 12'h123);
    check("filldone_pulse", fillDone, 1'b0);
    do_read(199, 149, 12'h123);
    do_read(10, 10, 12'h123);

    // Fill 456 aborted by reset after 100 pixels.
    DATIN = 12'h456; fill = 1'b1;
    tick();
    fill = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_wdbg", wDbg, 12'h000);
    tick();
    rst = 1'b0;
    $display("fill 456 aborted by reset");
    do_read(99, 0, 12'h456);
    do_read(100, 0, 12'h123);
    do_read(150, 0, 12'h123);

`ifdef FB_BOUNDS_CHECK_EN
    X = 8'd200; Y = 8'd0; DATIN = 12'h999; write = 1'b1;
    tick();
    write = 1'b0;
    check("oob_err", err, 1'b1);
    check("oob_wack", wAck, 1'b0);
    $display("write (200,0) rejected");
    do_read(0, 1, 12'h123);
`endif

    for (int i = 0; i < 6; i++) begin
      x = $urandom_range(0, 199);
      y = $urandom_range(2, 149);
      d = 12'($urandom);
      do_write(x, y, d);
      do_read(x, y, d);
    end

    check("err_idle", err, 1'b0);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
